// File: rtl/cp0_except_unit.sv
// cp0_except_unit
//   Coprocessor-0 state and exception-source logic for the 5-stage MIPS pipe.
//   Holds Count/Compare/Status/Cause/EPC/PRId. It prioritises MEM-stage
//   exception flags and pending interrupts into mem_excepttype, which the
//   control unit uses to flush and redirect. It commits the exception state
//   on the same clock edge.
// Ports
//   clk, reset            : clock (rising edge), synchronous active-high reset
//   int_i[5:0]            : level-sensitive hardware interrupt lines
//   mem_*                 : MEM-stage instruction valid/pc/delay-slot/exception flags
//   wb_cp0_we/waddr/wdata : mtc0 write port from WB
//   rd_addr / rd_data     : mfc0 read port (combinational, WB-bypassed)
//   mem_excepttype        : 0 none, 1..8 interrupt IP0..IP7, 9 sys, a RI, b Ov, c Tr, d eret
//   epc_o                 : EPC with same-cycle mtc0 bypass (eret target)
//   status_o, cause_o     : architectural Status / Cause
//   timer_int_o           : Count==Compare timer interrupt pending
module cp0_except_unit #(
  parameter logic [31:0] PRID      = 32'h0001_8000,
  parameter int          COUNT_DIV = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  int_i,
  input  logic        mem_valid,
  input  logic [31:0] mem_pc,
  input  logic        mem_in_delayslot,
  input  logic        mem_syscall,
  input  logic        mem_ri,
  input  logic        mem_ov,
  input  logic        mem_trap,
  input  logic        mem_eret,
  input  logic        wb_cp0_we,
  input  logic [4:0]  wb_cp0_waddr,
  input  logic [31:0] wb_cp0_wdata,
  input  logic [4:0]  rd_addr,
  output logic [31:0] rd_data,
  output logic [31:0] mem_excepttype,
  output logic [31:0] epc_o,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic        timer_int_o
);

  localparam logic [4:0] A_COUNT   = 5'd9;
  localparam logic [4:0] A_COMPARE = 5'd11;
  localparam logic [4:0] A_STATUS  = 5'd12;
  localparam logic [4:0] A_CAUSE   = 5'd13;
  localparam logic [4:0] A_EPC     = 5'd14;
  localparam logic [4:0] A_PRID    = 5'd15;
  localparam logic [7:0] DIV_LAST  = 8'(COUNT_DIV - 1);

  logic [31:0] r_count, r_compare, r_epc;
  logic [7:0]  r_div;
  logic        r_ie, r_exl, r_bd, r_timer_int;
  logic [7:0]  r_im, r_ip;
  logic [4:0]  r_exccode;

  logic        w_we_count, w_we_compare, w_we_status, w_we_cause, w_we_epc;
  logic        w_tick, w_int, w_commit, w_eret;
  logic [7:0]  w_pend;
  logic [4:0]  w_int_code, w_exccode;
  logic [31:0] w_status, w_cause;

  assign w_we_count   = wb_cp0_we && (wb_cp0_waddr == A_COUNT);
  assign w_we_compare = wb_cp0_we && (wb_cp0_waddr == A_COMPARE);
  assign w_we_status  = wb_cp0_we && (wb_cp0_waddr == A_STATUS);
  assign w_we_cause   = wb_cp0_we && (wb_cp0_waddr == A_CAUSE);
  assign w_we_epc     = wb_cp0_we && (wb_cp0_waddr == A_EPC);

  assign w_status = {16'b0, r_im, 6'b0, r_exl, r_ie};
  assign w_cause  = {r_bd, 15'b0, r_ip, 1'b0, r_exccode, 2'b0};

  assign status_o    = w_status;
  assign cause_o     = w_cause;
  assign timer_int_o = r_timer_int;
  assign epc_o       = w_we_epc ? wb_cp0_wdata : r_epc;

  assign w_tick = (r_div == DIV_LAST);

  // Interrupt is taken only with IE set and outside exception level.
  assign w_pend = r_ip & r_im;
  assign w_int  = (|w_pend) && r_ie && !r_exl;

  // Lowest pending IP index wins: scan high to low so the lowest set bit writes last.
  always_comb begin
    w_int_code = 5'd0;
    for (int i = 7; i >= 0; i--)
      if (w_pend[i]) w_int_code = 5'(i + 1);
  end

  always_comb begin
    mem_excepttype = 32'h0;
    if (!reset && mem_valid) begin
      if (w_int)            mem_excepttype = {27'b0, w_int_code};
      else if (mem_syscall) mem_excepttype = 32'h9;
      else if (mem_ri)      mem_excepttype = 32'ha;
      else if (mem_ov)      mem_excepttype = 32'hb;
      else if (mem_trap)    mem_excepttype = 32'hc;
      else if (mem_eret)    mem_excepttype = 32'hd;
    end
  end

  assign w_commit = (mem_excepttype != 32'h0) && (mem_excepttype <= 32'hc);
  assign w_eret   = (mem_excepttype == 32'hd);

  always_comb begin
    w_exccode = 5'd0;
    case (mem_excepttype[3:0])
      4'h9:    w_exccode = 5'd8;
      4'ha:    w_exccode = 5'd10;
      4'hb:    w_exccode = 5'd12;
      4'hc:    w_exccode = 5'd13;
      default: w_exccode = 5'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count     <= '0;
      r_compare   <= '0;
      r_epc       <= '0;
      r_div       <= '0;
      r_ie        <= 1'b0;
      r_exl       <= 1'b0;
      r_bd        <= 1'b0;
      r_timer_int <= 1'b0;
      r_im        <= '0;
      r_ip        <= '0;
      r_exccode   <= '0;
    end else begin
      if (w_we_count) begin
        r_count <= wb_cp0_wdata;
        r_div   <= '0;
      end else if (w_tick) begin
        r_count <= r_count + 32'd1;
        r_div   <= '0;
      end else begin
        r_div   <= r_div + 8'd1;
      end

      if (w_we_compare) begin
        r_compare   <= wb_cp0_wdata;
        r_timer_int <= 1'b0;
      end else if ((r_count == r_compare) && (r_compare != 32'h0)) begin
        r_timer_int <= 1'b1;
      end

      // IP7 is shared between int_i[5] and the timer.
      r_ip[7:2] <= {int_i[5] | r_timer_int, int_i[4:0]};
      if (w_we_cause) r_ip[1:0] <= wb_cp0_wdata[9:8];

      if (w_we_status) begin
        r_ie  <= wb_cp0_wdata[0];
        r_exl <= wb_cp0_wdata[1];
        r_im  <= wb_cp0_wdata[15:8];
      end
      if (w_we_epc) r_epc <= wb_cp0_wdata;

      // Exception/eret updates come last so they override mtc0 on EXL/EPC/BD.
      // With EXL already set, a re-committed exception (stalled pipe) keeps EPC/BD.
      if (w_commit) begin
        r_exccode <= w_exccode;
        if (!r_exl) begin
          r_epc <= mem_in_delayslot ? (mem_pc - 32'd4) : mem_pc;
          r_bd  <= mem_in_delayslot;
          r_exl <= 1'b1;
        end
      end else if (w_eret) begin
        r_exl <= 1'b0;
      end
    end
  end

  // mfc0 with same-cycle bypass of a WB write to the addressed register.
  always_comb begin
    rd_data = 32'h0;
    case (rd_addr)
      A_COUNT:   rd_data = w_we_count   ? wb_cp0_wdata : r_count;
      A_COMPARE: rd_data = w_we_compare ? wb_cp0_wdata : r_compare;
      A_STATUS:  rd_data = w_we_status  ? (wb_cp0_wdata & 32'h0000_ff03) : w_status;
      A_CAUSE:   rd_data = w_we_cause   ? {w_cause[31:10], wb_cp0_wdata[9:8], w_cause[7:0]}
                                        : w_cause;
      A_EPC:     rd_data = epc_o;
      A_PRID:    rd_data = PRID;
      default:   rd_data = 32'h0;
    endcase
  end

endmodule
